// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition codes and NZCVQ flag bit positions.
// Imported by Execute-stage units and by branch prediction checks.
package cpu_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  localparam int FLAG_N = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Q = 0;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator over the N,Z,C,V flags.
// Encoding 4'hF behaves like AL (always passes).
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:1] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b1;
    unique case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      default: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/cond_flag_unit.sv
// Execute-stage NZCVQ flag register, condition gating of writes/branch,
// sticky saturation flag and saturating executed/skipped counters.
module cond_flag_unit
  import cpu_pkg::*;
#(
  parameter int CNT_WIDTH   = 16,
  parameter int FLAGS_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_e,
  input  logic                   stall_e,
  input  logic                   flush_e,
  input  logic [3:0]             cond_e,
  input  logic [1:0]             flag_write_e,
  input  logic                   q_write_e,
  input  logic                   q_clear,
  input  logic [FLAGS_WIDTH-1:0] alu_flags_e,
  input  logic                   reg_write_e,
  input  logic                   mem_write_e,
  input  logic                   branch_e,
  input  logic                   cnt_clear,
  output logic [FLAGS_WIDTH-1:0] flags,
  output logic                   carry_out,
  output logic                   cond_pass,
  output logic                   reg_write_g,
  output logic                   mem_write_g,
  output logic                   branch_taken,
  output logic [CNT_WIDTH-1:0]   exec_count,
  output logic [CNT_WIDTH-1:0]   skip_count
);

  logic [FLAGS_WIDTH-1:0] flags_q, flags_d;
  logic [CNT_WIDTH-1:0]   exec_q, exec_d;
  logic [CNT_WIDTH-1:0]   skip_q, skip_d;
  logic                   update;
  logic                   live;
  logic                   commit;
  logic                   q_set;

  cond_eval u_cond_eval (
    .cond  (cond_e),
    .flags (flags_q[4:1]),
    .pass  (cond_pass)
  );

  assign update = valid_e & ~stall_e & ~flush_e;
  assign commit = update & cond_pass;
  assign q_set  = commit & q_write_e & alu_flags_e[FLAG_Q];

  // Gated outputs ignore stall; the consumer qualifies them itself.
  assign live         = valid_e & ~flush_e & cond_pass;
  assign reg_write_g  = reg_write_e & live;
  assign mem_write_g  = mem_write_e & live;
  assign branch_taken = branch_e & live;

  always_comb begin
    flags_d = flags_q;
    if (commit && flag_write_e[1]) begin
      flags_d[FLAG_N] = alu_flags_e[FLAG_N];
      flags_d[FLAG_Z] = alu_flags_e[FLAG_Z];
    end
    if (commit && flag_write_e[0]) begin
      flags_d[FLAG_C] = alu_flags_e[FLAG_C];
      flags_d[FLAG_V] = alu_flags_e[FLAG_V];
    end
    // A set in the same cycle as an explicit clear must win.
    if (q_clear) flags_d[FLAG_Q] = 1'b0;
    if (q_set)   flags_d[FLAG_Q] = 1'b1;
  end

  always_comb begin
    exec_d = exec_q;
    skip_d = skip_q;
    if (cnt_clear) begin
      exec_d = '0;
      skip_d = '0;
    end else if (update) begin
      if (cond_pass) begin
        if (!(&exec_q)) exec_d = exec_q + CNT_WIDTH'(1);
      end else begin
        if (!(&skip_q)) skip_d = skip_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
      exec_q  <= '0;
      skip_q  <= '0;
    end else begin
      flags_q <= flags_d;
      exec_q  <= exec_d;
      skip_q  <= skip_d;
    end
  end

  assign flags      = flags_q;
  assign carry_out  = flags_q[FLAG_C];
  assign exec_count = exec_q;
  assign skip_count = skip_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed vector bench for cond_flag_unit, with a narrow-counter
// instance alongside the default one for saturation checks.
module tb_cond_flag_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       valid_e = 1'b0;
  logic       stall_e = 1'b0;
  logic       flush_e = 1'b0;
  logic [3:0] cond_e = 4'h0;
  logic [1:0] flag_write_e = 2'b00;
  logic       q_write_e = 1'b0;
  logic       q_clear = 1'b0;
  logic [4:0] alu_flags_e = 5'b0;
  logic       reg_write_e = 1'b0;
  logic       mem_write_e = 1'b0;
  logic       branch_e = 1'b0;
  logic       cnt_clear = 1'b0;

  logic [4:0]  flags, flags4;
  logic        carry_out, carry_out4;
  logic        cond_pass, cond_pass4;
  logic        reg_write_g, reg_write_g4;
  logic        mem_write_g, mem_write_g4;
  logic        branch_taken, branch_taken4;
  logic [15:0] exec_count, skip_count;
  logic [3:0]  exec_count4, skip_count4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cond_flag_unit #(.CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .valid_e(valid_e), .stall_e(stall_e),
    .flush_e(flush_e), .cond_e(cond_e), .flag_write_e(flag_write_e),
    .q_write_e(q_write_e), .q_clear(q_clear), .alu_flags_e(alu_flags_e),
    .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
    .branch_e(branch_e), .cnt_clear(cnt_clear),
    .flags(flags), .carry_out(carry_out), .cond_pass(cond_pass),
    .reg_write_g(reg_write_g), .mem_write_g(mem_write_g),
    .branch_taken(branch_taken), .exec_count(exec_count),
    .skip_count(skip_count)
  );

  cond_flag_unit #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .valid_e(valid_e), .stall_e(stall_e),
    .flush_e(flush_e), .cond_e(cond_e), .flag_write_e(flag_write_e),
    .q_write_e(q_write_e), .q_clear(q_clear), .alu_flags_e(alu_flags_e),
    .reg_write_e(reg_write_e), .mem_write_e(mem_write_e),
    .branch_e(branch_e), .cnt_clear(cnt_clear),
    .flags(flags4), .carry_out(carry_out4), .cond_pass(cond_pass4),
    .reg_write_g(reg_write_g4), .mem_write_g(mem_write_g4),
    .branch_taken(branch_taken4), .exec_count(exec_count4),
    .skip_count(skip_count4)
  );

  typedef struct {
    logic [3:0] cond;
    logic [1:0] fw;
    logic       qw;
    logic       qc;
    logic [4:0] alu;
    logic [2:0] vsf;
    logic [2:0] req;
    logic       cc;
    logic [3:0] e_g;
    logic [4:0] e_flags;
    int         e_exec;
    int         e_skip;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic [3:0] c, input logic [1:0] fw,
    input logic qw, input logic qc, input logic [4:0] alu,
    input logic [2:0] vsf, input logic [2:0] req, input logic cc,
    input logic [3:0] g, input logic [4:0] ef,
    input int ee, input int es);
    vec_t r;
    r.cond = c; r.fw = fw; r.qw = qw; r.qc = qc; r.alu = alu;
    r.vsf = vsf; r.req = req; r.cc = cc; r.e_g = g;
    r.e_flags = ef; r.e_exec = ee; r.e_skip = es;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    valid_e = 0; stall_e = 0; flush_e = 0; cond_e = 4'hE;
    flag_write_e = 0; q_write_e = 0; q_clear = 0; alu_flags_e = 0;
    reg_write_e = 0; mem_write_e = 0; branch_e = 0; cnt_clear = 0;
  endtask

  task automatic drive(input vec_t v);
    cond_e = v.cond; flag_write_e = v.fw; q_write_e = v.qw;
    q_clear = v.qc; alu_flags_e = v.alu;
    {valid_e, stall_e, flush_e} = v.vsf;
    {reg_write_e, mem_write_e, branch_e} = v.req;
    cnt_clear = v.cc;
  endtask

  initial begin
    // cond fw qw qc alu vsf req cc | pass/rw/mw/br flags exec skip
    vecs.push_back(mk(4'h0,0,0,0,5'b00000,3'b100,3'b000,0,4'b0000,5'b00000,0,1));
    vecs.push_back(mk(4'hE,3,0,0,5'b01000,3'b100,3'b000,0,4'b1000,5'b01000,1,1));
    vecs.push_back(mk(4'h0,0,0,0,5'b00000,3'b100,3'b111,0,4'b1111,5'b01000,2,1));
    vecs.push_back(mk(4'hE,3,0,0,5'b10000,3'b100,3'b000,0,4'b1000,5'b10000,3,1));
    vecs.push_back(mk(4'hA,0,0,0,5'b00000,3'b100,3'b000,0,4'b0000,5'b10000,3,2));
    vecs.push_back(mk(4'hB,0,0,0,5'b00000,3'b100,3'b001,0,4'b1001,5'b10000,4,2));
    vecs.push_back(mk(4'hE,1,0,0,5'b00010,3'b100,3'b000,0,4'b1000,5'b10010,5,2));
    vecs.push_back(mk(4'hA,0,0,0,5'b00000,3'b100,3'b000,0,4'b1000,5'b10010,6,2));
    vecs.push_back(mk(4'hC,0,0,0,5'b00000,3'b100,3'b000,0,4'b1000,5'b10010,7,2));
    vecs.push_back(mk(4'hE,2,0,0,5'b11000,3'b100,3'b000,0,4'b1000,5'b11010,8,2));
    vecs.push_back(mk(4'hD,0,0,0,5'b00000,3'b100,3'b000,0,4'b1000,5'b11010,9,2));
    vecs.push_back(mk(4'hC,0,0,0,5'b00000,3'b100,3'b000,0,4'b0000,5'b11010,9,3));
    vecs.push_back(mk(4'hE,0,1,0,5'b00001,3'b100,3'b000,0,4'b1000,5'b11011,10,3));
    vecs.push_back(mk(4'hE,0,1,0,5'b00000,3'b100,3'b000,0,4'b1000,5'b11011,11,3));
    vecs.push_back(mk(4'hE,0,1,1,5'b00001,3'b100,3'b000,0,4'b1000,5'b11011,12,3));
    vecs.push_back(mk(4'hE,0,0,1,5'b00000,3'b000,3'b100,0,4'b1000,5'b11010,12,3));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(4'hE,3,0,0,5'b00000,3'b110,3'b100,0,4'b1100,5'b11010,12,3));
    vecs.push_back(mk(4'hE,3,0,0,5'b00000,3'b101,3'b100,0,4'b1000,5'b11010,12,3));
    vecs.push_back(mk(4'hE,1,0,0,5'b00100,3'b100,3'b000,0,4'b1000,5'b11100,13,3));
    vecs.push_back(mk(4'h3,1,0,0,5'b00000,3'b100,3'b000,0,4'b0000,5'b11100,13,4));
    vecs.push_back(mk(4'h6,0,0,0,5'b00000,3'b100,3'b000,0,4'b0000,5'b11100,13,5));
    vecs.push_back(mk(4'h4,0,0,0,5'b00000,3'b100,3'b000,0,4'b1000,5'b11100,14,5));
    vecs.push_back(mk(4'h5,0,0,0,5'b00000,3'b100,3'b000,0,4'b0000,5'b11100,14,6));
    vecs.push_back(mk(4'h8,0,0,0,5'b00000,3'b100,3'b000,0,4'b0000,5'b11100,14,7));
    vecs.push_back(mk(4'h9,0,0,0,5'b00000,3'b100,3'b000,0,4'b1000,5'b11100,15,7));
    vecs.push_back(mk(4'hF,0,0,0,5'b00000,3'b100,3'b000,0,4'b1000,5'b11100,16,7));
    vecs.push_back(mk(4'h1,0,0,0,5'b00000,3'b100,3'b000,0,4'b0000,5'b11100,16,8));
    vecs.push_back(mk(4'h2,0,0,0,5'b00000,3'b100,3'b000,0,4'b1000,5'b11100,17,8));
    vecs.push_back(mk(4'h7,0,0,0,5'b00000,3'b100,3'b000,0,4'b1000,5'b11100,18,8));
    vecs.push_back(mk(4'hE,0,0,0,5'b00000,3'b100,3'b000,1,4'b1000,5'b11100,0,0));

    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 0;
    chk("reset_flags", flags, 5'b0);
    chk("reset_carry", carry_out, 1'b0);
    chk("reset_exec", exec_count, 16'd0);
    chk("reset_skip", skip_count, 16'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_pass", i), cond_pass, vecs[i].e_g[3]);
      chk($sformatf("v%0d_rwg", i), reg_write_g, vecs[i].e_g[2]);
      chk($sformatf("v%0d_mwg", i), mem_write_g, vecs[i].e_g[1]);
      chk($sformatf("v%0d_br", i), branch_taken, vecs[i].e_g[0]);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_flags", i), flags, vecs[i].e_flags);
      chk($sformatf("v%0d_carry", i), carry_out, vecs[i].e_flags[2]);
      chk($sformatf("v%0d_exec", i), exec_count, vecs[i].e_exec);
      chk($sformatf("v%0d_skip", i), skip_count, vecs[i].e_skip);
    end
    chk("cnt4_clear_exec", exec_count4, 4'd0);

    // Saturation of the narrow counter over 20 passing retires.
    @(negedge clk);
    idle();
    valid_e = 1;
    repeat (20) @(negedge clk);
    chk("sat_exec4", exec_count4, 4'hF);
    chk("sat_skip4", skip_count4, 4'h0);
    chk("sat_exec16", exec_count, 16'd20);
    chk("sat_flags4", flags4, 5'b11100);

    // Clear together with a retire yields zero.
    cnt_clear = 1;
    @(negedge clk);
    cnt_clear = 0;
    chk("clr_exec4", exec_count4, 4'h0);
    chk("clr_exec16", exec_count, 16'd0);

    // Reset overrides a flag-writing retire in the same cycle.
    flag_write_e = 2'b11; q_write_e = 1; alu_flags_e = 5'b11111;
    reset = 1;
    @(negedge clk);
    reset = 0;
    idle();
    chk("rst_mid_flags", flags, 5'b0);
    chk("rst_mid_exec", exec_count, 16'd0);
    chk("rst_mid_carry", carry_out, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
